// File: rtl/l2_tag_lookup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_tag_lookup_pkg
// Description : Shared L2 cache types, sizes and state encodings used by the
//               tag lookup stage and its priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_tag_lookup_pkg;

  localparam int L2_WAYS     = 8;
  localparam int L2_WAY_BITS = $clog2(L2_WAYS);
  localparam int L2_SET_BITS = 8;
  localparam int L2_TAG_BITS = 16;
  localparam int LINE_BITS   = 128;
  localparam int HPROT_BITS  = 1;
  localparam int STATE_BITS  = 2;

  typedef logic [L2_WAY_BITS-1:0] l2_way_t;
  typedef logic [L2_TAG_BITS-1:0] l2_tag_t;
  typedef logic [STATE_BITS-1:0]  state_t;
  typedef logic [HPROT_BITS-1:0]  hprot_t;
  typedef logic [LINE_BITS-1:0]   line_t;

  // Coherence state encodings; INVALID must stay all-zeros so a cleared
  // memory reads back as empty ways.
  localparam state_t INVALID   = 2'd0;
  localparam state_t SHARED    = 2'd1;
  localparam state_t EXCLUSIVE = 2'd2;
  localparam state_t MODIFIED  = 2'd3;

  typedef enum logic [1:0] {
    L2_LOOKUP_IDLE = 2'd0,
    L2_LOOKUP_READ = 2'd1,
    L2_LOOKUP_RESP = 2'd2
  } l2_lookup_state_t;

  // Next way in round-robin order, wrapping the last way back to 0.
  function automatic int l2_way_wrap_inc(input int way, input int ways);
    return (way >= ways - 1) ? 0 : way + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_way_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : l2_way_prio_enc
// Description : Lowest-index-wins priority encoder over a per-way request
//               vector; returns whether any bit is set and its index.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_way_prio_enc
  import l2_tag_lookup_pkg::*;
#(
  parameter  int WAYS     = L2_WAYS,
  localparam int IDX_BITS = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]     req,
  output logic                found,
  output logic [IDX_BITS-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (req[w]) begin
        found = 1'b1;
        idx   = IDX_BITS'(w);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_tag_lookup.sv
`default_nettype none
// ============================================================================
// Module      : l2_tag_lookup
// Description : L2 tag lookup stage. Issues a set read to the local memory,
//               compares the returned tags/states of every way and presents
//               a registered hit/victim result under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_tag_lookup
  import l2_tag_lookup_pkg::*;
#(
  parameter  int WAYS     = L2_WAYS,
  parameter  int TAG_BITS = L2_TAG_BITS,
  parameter  int SET_BITS = L2_SET_BITS,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [TAG_BITS+SET_BITS-1:0]        req_addr,
  input  logic                                mem_busy,
  output logic                                mem_rd_en,
  output logic [SET_BITS-1:0]                 mem_set,
  input  logic [WAYS-1:0][LINE_BITS-1:0]      mem_rd_line,
  input  logic [WAYS-1:0][TAG_BITS-1:0]       mem_rd_tag,
  input  logic [WAYS-1:0][HPROT_BITS-1:0]     mem_rd_hprot,
  input  logic [WAYS-1:0][STATE_BITS-1:0]     mem_rd_state,
  input  logic [WAY_BITS-1:0]                 mem_rd_evict_way,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic                                rsp_hit,
  output logic [WAY_BITS-1:0]                 rsp_way,
  output logic                                rsp_empty,
  output logic [TAG_BITS-1:0]                 rsp_tag,
  output logic [STATE_BITS-1:0]               rsp_state,
  output logic [HPROT_BITS-1:0]               rsp_hprot,
  output logic [LINE_BITS-1:0]                rsp_line,
  output logic [SET_BITS-1:0]                 rsp_set,
  output logic [WAY_BITS-1:0]                 rsp_evict_next
);

  localparam logic [1:0] C_ST_IDLE = 2'(L2_LOOKUP_IDLE);
  localparam logic [1:0] C_ST_READ = 2'(L2_LOOKUP_READ);
  localparam logic [1:0] C_ST_RESP = 2'(L2_LOOKUP_RESP);

  logic [1:0]            r_state;
  logic [TAG_BITS-1:0]   r_tag;
  logic [SET_BITS-1:0]   r_set;

  logic                  r_rsp_valid;
  logic                  r_rsp_hit;
  logic                  r_rsp_empty;
  logic [WAY_BITS-1:0]   r_rsp_way;
  logic [TAG_BITS-1:0]   r_rsp_tag;
  logic [STATE_BITS-1:0] r_rsp_state;
  logic [HPROT_BITS-1:0] r_rsp_hprot;
  logic [LINE_BITS-1:0]  r_rsp_line;
  logic [SET_BITS-1:0]   r_rsp_set;
  logic [WAY_BITS-1:0]   r_rsp_evict_next;

  logic                  w_idle;
  logic                  w_accept;
  logic [WAYS-1:0]       w_match;
  logic [WAYS-1:0]       w_inv;
  logic                  w_hit;
  logic                  w_inv_found;
  logic [WAY_BITS-1:0]   w_hit_way;
  logic [WAY_BITS-1:0]   w_inv_way;
  logic [WAY_BITS-1:0]   w_sel_way;

  // Requests are only taken in IDLE and never while the memory is being
  // written, since the read port is shared with that write.
  assign w_idle    = (r_state == C_ST_IDLE);
  assign req_ready = w_idle & ~mem_busy;
  assign w_accept  = req_valid & req_ready;
  assign mem_rd_en = w_accept;
  assign mem_set   = w_idle ? req_addr[SET_BITS-1:0] : r_set;

  // Per-way tag compare; an INVALID way never counts as a match even if its
  // stale tag happens to equal the request.
  always_comb begin
    w_match = '0;
    w_inv   = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_inv[w]   = (mem_rd_state[w] == INVALID);
      w_match[w] = (mem_rd_tag[w] == r_tag) & ~w_inv[w];
    end
  end

  l2_way_prio_enc #(
    .WAYS  (WAYS)
  ) u_match_enc (
    .req   (w_match),
    .found (w_hit),
    .idx   (w_hit_way)
  );

  l2_way_prio_enc #(
    .WAYS  (WAYS)
  ) u_inv_enc (
    .req   (w_inv),
    .found (w_inv_found),
    .idx   (w_inv_way)
  );

  // Way selection: hit way, else first free way, else the round-robin victim.
  always_comb begin
    if (w_hit) begin
      w_sel_way = w_hit_way;
    end else if (w_inv_found) begin
      w_sel_way = w_inv_way;
    end else begin
      w_sel_way = mem_rd_evict_way;
    end
  end

  // Control FSM: IDLE -> READ (memory data arrives) -> RESP (hold result).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= C_ST_IDLE;
      r_tag   <= '0;
      r_set   <= '0;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (w_accept) begin
            r_tag   <= req_addr[TAG_BITS+SET_BITS-1:SET_BITS];
            r_set   <= req_addr[SET_BITS-1:0];
            r_state <= C_ST_READ;
          end
        end
        C_ST_READ: r_state <= C_ST_RESP;
        C_ST_RESP: begin
          if (rsp_ready) begin
            r_state <= C_ST_IDLE;
          end
        end
        default:   r_state <= C_ST_IDLE;
      endcase
    end
  end

  // Capture the selected way's contents once, then hold them until consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid      <= 1'b0;
      r_rsp_hit        <= 1'b0;
      r_rsp_empty      <= 1'b0;
      r_rsp_way        <= '0;
      r_rsp_tag        <= '0;
      r_rsp_state      <= '0;
      r_rsp_hprot      <= '0;
      r_rsp_line       <= '0;
      r_rsp_set        <= '0;
      r_rsp_evict_next <= '0;
    end else if (r_state == C_ST_READ) begin
      r_rsp_valid      <= 1'b1;
      r_rsp_hit        <= w_hit;
      r_rsp_empty      <= ~w_hit & w_inv_found;
      r_rsp_way        <= w_sel_way;
      r_rsp_tag        <= mem_rd_tag[w_sel_way];
      r_rsp_state      <= mem_rd_state[w_sel_way];
      r_rsp_hprot      <= mem_rd_hprot[w_sel_way];
      r_rsp_line       <= mem_rd_line[w_sel_way];
      r_rsp_set        <= r_set;
      r_rsp_evict_next <= WAY_BITS'(l2_way_wrap_inc(32'(w_sel_way), WAYS));
    end else if ((r_state == C_ST_RESP) && rsp_ready) begin
      r_rsp_valid      <= 1'b0;
    end
  end

  assign rsp_valid      = r_rsp_valid;
  assign rsp_hit        = r_rsp_hit;
  assign rsp_empty      = r_rsp_empty;
  assign rsp_way        = r_rsp_way;
  assign rsp_tag        = r_rsp_tag;
  assign rsp_state      = r_rsp_state;
  assign rsp_hprot      = r_rsp_hprot;
  assign rsp_line       = r_rsp_line;
  assign rsp_set        = r_rsp_set;
  assign rsp_evict_next = r_rsp_evict_next;

endmodule
`default_nettype wire

// File: tb/tb_l2_tag_lookup.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_l2_tag_lookup
// Description : Directed plus randomised self-checking bench for
//               l2_tag_lookup with a scoreboard of expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_tag_lookup;
  import l2_tag_lookup_pkg::*;

  localparam int WAYS = L2_WAYS;
  localparam int TBW  = L2_TAG_BITS;
  localparam int SBW  = L2_SET_BITS;
  localparam int WBW  = L2_WAY_BITS;

  logic                              clk = 1'b0;
  logic                              rst = 1'b0;
  logic                              req_valid = 1'b0;
  logic                              req_ready;
  logic [TBW+SBW-1:0]                req_addr = '0;
  logic                              mem_busy = 1'b0;
  logic                              mem_rd_en;
  logic [SBW-1:0]                    mem_set;
  logic [WAYS-1:0][LINE_BITS-1:0]    mem_rd_line;
  logic [WAYS-1:0][TBW-1:0]          mem_rd_tag;
  logic [WAYS-1:0][HPROT_BITS-1:0]   mem_rd_hprot;
  logic [WAYS-1:0][STATE_BITS-1:0]   mem_rd_state;
  logic [WBW-1:0]                    mem_rd_evict_way;
  logic                              rsp_valid;
  logic                              rsp_ready = 1'b0;
  logic                              rsp_hit;
  logic [WBW-1:0]                    rsp_way;
  logic                              rsp_empty;
  logic [TBW-1:0]                    rsp_tag;
  logic [STATE_BITS-1:0]             rsp_state;
  logic [HPROT_BITS-1:0]             rsp_hprot;
  logic [LINE_BITS-1:0]              rsp_line;
  logic [SBW-1:0]                    rsp_set;
  logic [WBW-1:0]                    rsp_evict_next;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory image seen on the read port.
  l2_tag_t m_tag   [WAYS];
  state_t  m_state [WAYS];
  hprot_t  m_hprot [WAYS];
  line_t   m_line  [WAYS];
  l2_way_t m_evict = '0;

  typedef struct packed {
    logic           hit;
    logic [WBW-1:0] way;
    logic           empty;
    l2_tag_t        tag;
    state_t         state;
    hprot_t         hprot;
    line_t          line;
    logic [SBW-1:0] set;
    logic [WBW-1:0] evict_next;
  } exp_t;

  exp_t sb_q [$];
  exp_t cur;

  always #5 clk = ~clk;

  always_comb begin
    mem_rd_tag       = '0;
    mem_rd_state     = '0;
    mem_rd_hprot     = '0;
    mem_rd_line      = '0;
    mem_rd_evict_way = m_evict;
    for (int w = 0; w < WAYS; w++) begin
      mem_rd_tag[w]   = m_tag[w];
      mem_rd_state[w] = m_state[w];
      mem_rd_hprot[w] = m_hprot[w];
      mem_rd_line[w]  = m_line[w];
    end
  end

  l2_tag_lookup dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .mem_busy         (mem_busy),
    .mem_rd_en        (mem_rd_en),
    .mem_set          (mem_set),
    .mem_rd_line      (mem_rd_line),
    .mem_rd_tag       (mem_rd_tag),
    .mem_rd_hprot     (mem_rd_hprot),
    .mem_rd_state     (mem_rd_state),
    .mem_rd_evict_way (mem_rd_evict_way),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_hit          (rsp_hit),
    .rsp_way          (rsp_way),
    .rsp_empty        (rsp_empty),
    .rsp_tag          (rsp_tag),
    .rsp_state        (rsp_state),
    .rsp_hprot        (rsp_hprot),
    .rsp_line         (rsp_line),
    .rsp_set          (rsp_set),
    .rsp_evict_next   (rsp_evict_next)
  );

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Reference behaviour: first valid tag match, else first invalid way,
  // else the stored round-robin pointer.
  function automatic exp_t model(input l2_tag_t tag, input logic [SBW-1:0] set);
    exp_t e;
    int   sel;
    e   = '0;
    sel = -1;
    for (int w = 0; w < WAYS; w++)
      if (sel < 0 && m_state[w] != INVALID && m_tag[w] == tag) sel = w;
    if (sel >= 0) begin
      e.hit = 1'b1;
    end else begin
      for (int w = 0; w < WAYS; w++)
        if (sel < 0 && m_state[w] == INVALID) sel = w;
      if (sel >= 0) e.empty = 1'b1;
      else          sel = int'(m_evict);
    end
    e.way        = WBW'(sel);
    e.tag        = m_tag[sel];
    e.state      = m_state[sel];
    e.hprot      = m_hprot[sel];
    e.line       = m_line[sel];
    e.set        = set;
    e.evict_next = WBW'((sel + 1) % WAYS);
    return e;
  endfunction

  task automatic fill_random();
    for (int w = 0; w < WAYS; w++) begin
      m_tag[w]   = l2_tag_t'($urandom_range(15, 0));
      m_state[w] = state_t'($urandom_range(3, 0));
      m_hprot[w] = hprot_t'($urandom_range(1, 0));
      m_line[w]  = {$urandom, $urandom, $urandom, $urandom};
    end
    m_evict = l2_way_t'($urandom_range(WAYS - 1, 0));
  endtask

  task automatic fill_distinct(input l2_tag_t base, input state_t st);
    for (int w = 0; w < WAYS; w++) begin
      m_tag[w]   = base + l2_tag_t'(w);
      m_state[w] = st;
      m_hprot[w] = hprot_t'(w & 1);
      m_line[w]  = {4{32'hC0DE_0000 | 32'(w)}};
    end
  endtask

  // Call right after a falling edge: drive, check issue, then step into READ.
  task automatic start_lookup(input string name, input l2_tag_t tag, input logic [SBW-1:0] set);
    req_valid = 1'b1;
    req_addr  = {tag, set};
    #1;
    check({name, " req_ready"}, 128'(req_ready), 128'(1'b1));
    check({name, " mem_rd_en"}, 128'(mem_rd_en), 128'(1'b1));
    check({name, " mem_set"},   128'(mem_set),   128'(set));
    sb_q.push_back(model(tag, set));
    @(negedge clk);
    req_valid = 1'b0;
    check({name, " valid_in_read"}, 128'(rsp_valid), 128'(1'b0));
  endtask

  task automatic compare_rsp(input string name, input exp_t e);
    check({name, " hit"},        128'(rsp_hit),        128'(e.hit));
    check({name, " way"},        128'(rsp_way),        128'(e.way));
    check({name, " empty"},      128'(rsp_empty),      128'(e.empty));
    check({name, " tag"},        128'(rsp_tag),        128'(e.tag));
    check({name, " state"},      128'(rsp_state),      128'(e.state));
    check({name, " hprot"},      128'(rsp_hprot),      128'(e.hprot));
    check({name, " line"},       128'(rsp_line),       128'(e.line));
    check({name, " set"},        128'(rsp_set),        128'(e.set));
    check({name, " evict_next"}, 128'(rsp_evict_next), 128'(e.evict_next));
  endtask

  task automatic wait_rsp(input string name);
    @(negedge clk);
    check({name, " rsp_valid"}, 128'(rsp_valid), 128'(1'b1));
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard: observed empty queue expected one entry", name);
      cur = '0;
    end else begin
      cur = sb_q.pop_front();
    end
    compare_rsp(name, cur);
  endtask

  task automatic release_rsp(input string name);
    rsp_ready = 1'b1;
    @(negedge clk);
    check({name, " valid_cleared"}, 128'(rsp_valid), 128'(1'b0));
    check({name, " idle_ready"},    128'(req_ready), 128'(1'b1));
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_distinct(16'h3000, SHARED);

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset rsp_valid", 128'(rsp_valid), 128'(1'b0));
    check("reset rsp_way",   128'(rsp_way),   128'(0));
    check("reset mem_rd_en", 128'(mem_rd_en), 128'(1'b0));
    check("reset rsp_hit",   128'(rsp_hit),   128'(1'b0));
    req_valid = 1'b1;
    req_addr  = {16'h0055, 8'h3C};
    #1;
    check("reset req_ready", 128'(req_ready), 128'(1'b1));
    check("reset mem_set",   128'(mem_set),   128'(8'h3C));
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Hit on way 5
    fill_distinct(16'h1000, EXCLUSIVE);
    m_tag[5] = 16'h01A3; m_state[5] = SHARED; m_evict = 3'd1;
    @(negedge clk);
    start_lookup("hit5", 16'h01A3, 8'h40);
    wait_rsp("hit5");
    check("hit5 const hit",  128'(rsp_hit),        128'(1'b1));
    check("hit5 const way",  128'(rsp_way),        128'(5));
    check("hit5 const next", 128'(rsp_evict_next), 128'(6));
    release_rsp("hit5");

    // Miss with free ways 2 and 6; way 2 holds a stale matching tag
    fill_distinct(16'h2000, MODIFIED);
    m_state[2] = INVALID; m_tag[2] = 16'h01A3; m_state[6] = INVALID; m_evict = 3'd4;
    @(negedge clk);
    start_lookup("empty2", 16'h01A3, 8'h11);
    wait_rsp("empty2");
    check("empty2 const hit",   128'(rsp_hit),   128'(1'b0));
    check("empty2 const empty", 128'(rsp_empty), 128'(1'b1));
    check("empty2 const way",   128'(rsp_way),   128'(2));
    release_rsp("empty2");

    // Miss, all ways valid, victim pointer at the last way
    fill_distinct(16'h4000, SHARED);
    m_evict = 3'd7;
    @(negedge clk);
    start_lookup("evict7", 16'h0BAD, 8'hFF);
    wait_rsp("evict7");
    check("evict7 const way",   128'(rsp_way),        128'(7));
    check("evict7 const empty", 128'(rsp_empty),      128'(1'b0));
    check("evict7 const next",  128'(rsp_evict_next), 128'(0));
    release_rsp("evict7");

    // Two matching ways: lowest index wins
    fill_distinct(16'h5000, SHARED);
    m_tag[3] = 16'h0777; m_tag[6] = 16'h0777;
    @(negedge clk);
    start_lookup("multi", 16'h0777, 8'h00);
    wait_rsp("multi");
    check("multi const way", 128'(rsp_way), 128'(3));
    release_rsp("multi");

    // Hold under back-pressure while memory inputs churn
    fill_distinct(16'h6000, EXCLUSIVE);
    m_tag[0] = 16'h0042;
    @(negedge clk);
    start_lookup("hold", 16'h0042, 8'h9A);
    wait_rsp("hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fill_random();
      req_valid = 1'b1;
      req_addr  = {16'h0042, 8'h01};
      #1;
      compare_rsp("hold stable", cur);
      check("hold valid",     128'(rsp_valid), 128'(1'b1));
      check("hold req_ready", 128'(req_ready), 128'(1'b0));
      check("hold mem_rd_en", 128'(mem_rd_en), 128'(1'b0));
    end
    req_valid = 1'b0;
    release_rsp("hold");

    // Memory busy blocks acceptance for two cycles, then retry succeeds
    fill_distinct(16'h7000, SHARED);
    m_tag[4] = 16'h0123;
    @(negedge clk);
    mem_busy  = 1'b1;
    req_valid = 1'b1;
    req_addr  = {16'h0123, 8'h55};
    for (int i = 0; i < 2; i++) begin
      #1;
      check("busy req_ready", 128'(req_ready), 128'(1'b0));
      check("busy mem_rd_en", 128'(mem_rd_en), 128'(1'b0));
      check("busy rsp_valid", 128'(rsp_valid), 128'(1'b0));
      @(negedge clk);
    end
    mem_busy = 1'b0;
    start_lookup("busy_retry", 16'h0123, 8'h55);
    mem_busy = 1'b1;                 // ignored once the read is in flight
    wait_rsp("busy_retry");
    check("busy_retry const way", 128'(rsp_way), 128'(4));
    mem_busy = 1'b0;
    release_rsp("busy_retry");

    // rsp_ready high before the result exists has no effect
    rsp_ready = 1'b1;
    @(negedge clk);
    start_lookup("early_ready", 16'h7002, 8'h21);
    wait_rsp("early_ready");
    release_rsp("early_ready");

    // Reset during READ drops the request
    @(negedge clk);
    start_lookup("rst_read", 16'h7003, 8'h22);
    void'(sb_q.pop_back());
    rst = 1'b0;
    #1;
    check("rst_read valid_in_reset", 128'(rsp_valid), 128'(1'b0));
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_read valid_after", 128'(rsp_valid), 128'(1'b0));
    end
    check("rst_read idle_ready", 128'(req_ready), 128'(1'b1));
    req_valid = 1'b1;
    req_addr  = {16'h0001, 8'h77};
    #1;
    check("rst_read idle_rd_en", 128'(mem_rd_en), 128'(1'b1));
    check("rst_read idle_set",   128'(mem_set),   128'(8'h77));
    req_valid = 1'b0;

    // Randomised lookups over a small tag space to mix hits, empties, evicts
    for (int i = 0; i < 20; i++) begin
      l2_tag_t t;
      logic [SBW-1:0] s;
      fill_random();
      t = l2_tag_t'($urandom_range(15, 0));
      s = SBW'($urandom_range(255, 0));
      @(negedge clk);
      start_lookup("rand", t, s);
      wait_rsp("rand");
      release_rsp("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
